// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad entry path: debounce FSM states,
// entry-register limits and the time-validity helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } db_state_e;

  localparam int         MAX_DIGITS     = 4;
  localparam logic [3:0] MAX_SEC_TENS   = 4'd5;
  localparam logic [3:0] MAX_DIGIT_CODE = 4'd9;

  // An entry is usable once it holds a digit and the seconds-tens nibble is 0-5.
  function automatic logic time_is_valid(input logic [15:0] bcd,
                                         input logic [2:0]  count);
    return (count != 3'd0) && (bcd[7:4] <= MAX_SEC_TENS);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad input sampler plus press/release debounce FSM. accept_pulse is
// decoded from registered state only, so the parent can register it together
// with the entry update on the same edge.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] key_code,
  input  logic       no_key,
  output logic       accept_pulse,
  output logic [3:0] accept_code
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic [3:0]       smp_code_q, smp_code_d;
  logic             smp_nokey_q, smp_nokey_d;
  logic             smp_valid;

  assign smp_code_d  = key_code;
  assign smp_nokey_d = no_key;
  assign smp_valid   = !smp_nokey_q && (smp_code_q <= MAX_DIGIT_CODE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    accept_pulse = 1'b0;
    if (!enable) begin
      // A key already down when entry is re-enabled must be released first.
      state_d = smp_nokey_q ? IDLE : HELD;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (smp_valid) begin
            code_d  = smp_code_q;
            cnt_d   = CNT_W'(1);
            state_d = PRESS_DB;
          end
        end
        PRESS_DB: begin
          // Non-digit codes are treated like a release rather than a new press.
          if (!smp_valid) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else if (smp_code_q != code_q) begin
            code_d = smp_code_q;
            cnt_d  = CNT_W'(1);
          end else if (cnt_q == CNT_MAX - 1'b1) begin
            cnt_d        = '0;
            accept_pulse = 1'b1;
            state_d      = HELD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HELD: begin
          cnt_d = '0;
          if (smp_nokey_q) begin
            cnt_d   = CNT_W'(1);
            state_d = RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (!smp_nokey_q) begin
            cnt_d   = '0;
            state_d = HELD;
          end else if (cnt_q == CNT_MAX - 1'b1) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  assign accept_code = code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      code_q      <= 4'd0;
      smp_code_q  <= 4'd0;
      smp_nokey_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      smp_code_q  <= smp_code_d;
      smp_nokey_q <= smp_nokey_d;
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounced digits shift into a BCD MM:SS register
// that is handed to the cook timer on start. Optional key click: KEYPAD_BEEP_EN.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BEEP_CYCLES     = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [3:0]  key_code,
  input  logic        no_key,
  input  logic        clear,
  input  logic        start,
  output logic        key_accept,
  output logic [15:0] time_bcd,
  output logic [2:0]  digit_count,
  output logic        overflow,
  output logic        time_valid,
  output logic        load,
  output logic [15:0] time_out,
  output logic        entry_err,
  output logic        beep
);

  logic       accept_pulse;
  logic [3:0] accept_code;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .key_code    (key_code),
    .no_key      (no_key),
    .accept_pulse(accept_pulse),
    .accept_code (accept_code)
  );

  logic        key_accept_q, key_accept_d;
  logic [15:0] time_bcd_q, time_bcd_d;
  logic [2:0]  digit_count_q, digit_count_d;
  logic        overflow_q, overflow_d;
  logic        time_valid_q, time_valid_d;
  logic        load_q, load_d;
  logic [15:0] time_out_q, time_out_d;
  logic        entry_err_q, entry_err_d;

  always_comb begin
    key_accept_d  = accept_pulse;
    time_bcd_d    = time_bcd_q;
    digit_count_d = digit_count_q;
    overflow_d    = overflow_q;
    time_out_d    = time_out_q;
    load_d        = 1'b0;
    entry_err_d   = 1'b0;
    // clear beats start beats accept; a losing accept still pulses key_accept.
    if (clear) begin
      time_bcd_d    = 16'h0000;
      digit_count_d = 3'd0;
      overflow_d    = 1'b0;
    end else if (start && enable) begin
      if (time_valid_q) begin
        time_out_d    = time_bcd_q;
        load_d        = 1'b1;
        time_bcd_d    = 16'h0000;
        digit_count_d = 3'd0;
        overflow_d    = 1'b0;
      end else begin
        entry_err_d = 1'b1;
      end
    end else if (accept_pulse) begin
      if (digit_count_q < 3'(MAX_DIGITS)) begin
        time_bcd_d    = {time_bcd_q[11:0], accept_code};
        digit_count_d = digit_count_q + 3'd1;
      end else begin
        overflow_d = 1'b1;
      end
    end
    time_valid_d = time_is_valid(time_bcd_d, digit_count_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_accept_q  <= 1'b0;
      time_bcd_q    <= 16'h0000;
      digit_count_q <= 3'd0;
      overflow_q    <= 1'b0;
      time_valid_q  <= 1'b0;
      load_q        <= 1'b0;
      time_out_q    <= 16'h0000;
      entry_err_q   <= 1'b0;
    end else begin
      key_accept_q  <= key_accept_d;
      time_bcd_q    <= time_bcd_d;
      digit_count_q <= digit_count_d;
      overflow_q    <= overflow_d;
      time_valid_q  <= time_valid_d;
      load_q        <= load_d;
      time_out_q    <= time_out_d;
      entry_err_q   <= entry_err_d;
    end
  end

  assign key_accept  = key_accept_q;
  assign time_bcd    = time_bcd_q;
  assign digit_count = digit_count_q;
  assign overflow    = overflow_q;
  assign time_valid  = time_valid_q;
  assign load        = load_q;
  assign time_out    = time_out_q;
  assign entry_err   = entry_err_q;

`ifdef KEYPAD_BEEP_EN
  localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);

  logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
  logic              beep_q, beep_d;

  // Any new accept or rejected start restarts the click from full length.
  always_comb begin
    beep_cnt_d = beep_cnt_q;
    if (key_accept_d || entry_err_d) begin
      beep_cnt_d = BEEP_W'(BEEP_CYCLES);
    end else if (beep_cnt_q != '0) begin
      beep_cnt_d = beep_cnt_q - 1'b1;
    end
    beep_d = (beep_cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beep_cnt_q <= '0;
      beep_q     <= 1'b0;
    end else begin
      beep_cnt_q <= beep_cnt_d;
      beep_q     <= beep_d;
    end
  end

  assign beep = beep_q;
`else
  assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench for keypad_entry_ctrl: stimulus pushes hand-computed
// expected events, a negedge monitor pops them on key_accept/load/entry_err.
module tb_keypad_entry_ctrl;

  localparam int DB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [3:0]  key_code = 4'd0;
  logic        no_key = 1'b1;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        key_accept;
  logic [15:0] time_bcd;
  logic [2:0]  digit_count;
  logic        overflow;
  logic        time_valid;
  logic        load;
  logic [15:0] time_out;
  logic        entry_err;
  logic        beep;

  keypad_entry_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .BEEP_CYCLES    (1000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .key_code   (key_code),
    .no_key     (no_key),
    .clear      (clear),
    .start      (start),
    .key_accept (key_accept),
    .time_bcd   (time_bcd),
    .digit_count(digit_count),
    .overflow   (overflow),
    .time_valid (time_valid),
    .load       (load),
    .time_out   (time_out),
    .entry_err  (entry_err),
    .beep       (beep)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_ACC, EV_LOAD, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [15:0] bcd;
    logic [2:0]  cnt;
    logic        ovf;
    logic [15:0] tout;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   acc_seen     = 0;
  int   err_seen     = 0;
  int   snap;
  int   snap_err;
  int   first;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_acc(input logic [15:0] bcd, input logic [2:0] cnt, input logic ovf);
    exp_t e;
    e.kind = EV_ACC; e.bcd = bcd; e.cnt = cnt; e.ovf = ovf; e.tout = 16'h0;
    sbq.push_back(e);
  endtask

  task automatic exp_load(input logic [15:0] tout);
    exp_t e;
    e.kind = EV_LOAD; e.bcd = 16'h0; e.cnt = 3'd0; e.ovf = 1'b0; e.tout = tout;
    sbq.push_back(e);
  endtask

  task automatic exp_err(input logic [15:0] bcd, input logic [2:0] cnt);
    exp_t e;
    e.kind = EV_ERR; e.bcd = bcd; e.cnt = cnt; e.ovf = 1'b0; e.tout = 16'h0;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && (key_accept || load || entry_err)) begin
      if (key_accept) acc_seen++;
      if (entry_err)  err_seen++;
      if (sbq.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_event: acc=%0b load=%0b err=%0b bcd=0x%0h with nothing expected",
                 key_accept, load, entry_err, time_bcd);
      end else begin
        mon_e = sbq.pop_front();
        case (mon_e.kind)
          EV_ACC: begin
            check("acc_pulse", 32'(key_accept), 32'd1);
            check("acc_bcd",   32'(time_bcd),   32'(mon_e.bcd));
            check("acc_count", 32'(digit_count), 32'(mon_e.cnt));
            check("acc_ovf",   32'(overflow),   32'(mon_e.ovf));
          end
          EV_LOAD: begin
            check("load_pulse",    32'(load),        32'd1);
            check("load_time_out", 32'(time_out),    32'(mon_e.tout));
            check("load_bcd_clr",  32'(time_bcd),    32'h0);
            check("load_cnt_clr",  32'(digit_count), 32'd0);
          end
          default: begin
            check("err_pulse", 32'(entry_err),   32'd1);
            check("err_bcd",   32'(time_bcd),    32'(mon_e.bcd));
            check("err_count", 32'(digit_count), 32'(mon_e.cnt));
          end
        endcase
      end
    end
  end

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_code = code;
    no_key   = 1'b0;
    repeat (DB + 4) @(posedge clk);
    @(negedge clk);
    no_key = 1'b1;
    repeat (DB + 4) @(posedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_key_accept", 32'(key_accept), 32'd0);
    check("rst_time_bcd",   32'(time_bcd),   32'd0);
    check("rst_count",      32'(digit_count), 32'd0);
    check("rst_overflow",   32'(overflow),   32'd0);
    check("rst_time_valid", 32'(time_valid), 32'd0);
    check("rst_load",       32'(load),       32'd0);
    check("rst_time_out",   32'(time_out),   32'd0);
    check("rst_entry_err",  32'(entry_err),  32'd0);
    check("rst_beep",       32'(beep),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Single press of 7 with latency measurement
    exp_acc(16'h0007, 3'd1, 1'b0);
    @(negedge clk);
    key_code = 4'd7;
    no_key   = 1'b0;
    first    = 0;
    for (int i = 1; i <= DB + 3; i++) begin
      @(posedge clk);
      #1;
      if (key_accept && first == 0) first = i;
    end
    check("press_latency", 32'(first), 32'(DB + 1));
    @(negedge clk);
    no_key = 1'b1;
    repeat (DB + 4) @(posedge clk);
    @(negedge clk);
    check("t1_bcd",   32'(time_bcd),   32'h0007);
    check("t1_valid", 32'(time_valid), 32'd1);

    // Bouncing 3, then a stable hold
    do_clear();
    snap = acc_seen;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      key_code = 4'd3;
      no_key   = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      no_key = 1'b1;
      repeat (5) @(posedge clk);
    end
    @(negedge clk);
    check("bounce_no_early", 32'(acc_seen - snap), 32'd0);
    exp_acc(16'h0003, 3'd1, 1'b0);
    press(4'd3);
    check("bounce_one_accept", 32'(acc_seen - snap), 32'd1);

    // 1,2,3,0 then start
    do_clear();
    exp_acc(16'h0001, 3'd1, 1'b0); press(4'd1);
    exp_acc(16'h0012, 3'd2, 1'b0); press(4'd2);
    exp_acc(16'h0123, 3'd3, 1'b0); press(4'd3);
    exp_acc(16'h1230, 3'd4, 1'b0); press(4'd0);
    exp_load(16'h1230);
    do_start();
    @(negedge clk);
    check("t3_time_out_held", 32'(time_out),   32'h1230);
    check("t3_valid_cleared", 32'(time_valid), 32'd0);

    // Overflow on fifth digit, then invalid seconds
    do_clear();
    exp_acc(16'h0001, 3'd1, 1'b0); press(4'd1);
    exp_acc(16'h0012, 3'd2, 1'b0); press(4'd2);
    exp_acc(16'h0123, 3'd3, 1'b0); press(4'd3);
    exp_acc(16'h1234, 3'd4, 1'b0); press(4'd4);
    exp_acc(16'h1234, 3'd4, 1'b1); press(4'd5);
    check("t4_overflow", 32'(overflow), 32'd1);
    do_clear();
    @(negedge clk);
    check("t4_overflow_cleared", 32'(overflow), 32'd0);
    exp_acc(16'h0001, 3'd1, 1'b0); press(4'd1);
    exp_acc(16'h0017, 3'd2, 1'b0); press(4'd7);
    exp_acc(16'h0175, 3'd3, 1'b0); press(4'd5);
    check("t4_valid_low", 32'(time_valid), 32'd0);
    exp_err(16'h0175, 3'd3);
    do_start();
    @(negedge clk);
    check("t4_bcd_kept",     32'(time_bcd), 32'h0175);
    check("t4_time_out_old", 32'(time_out), 32'h1230);
    do_clear();
    exp_err(16'h0000, 3'd0);
    do_start();

    // clear coincident with an accept: pulse seen, entry untouched
    exp_acc(16'h0000, 3'd0, 1'b0);
    @(negedge clk);
    key_code = 4'd4;
    no_key   = 1'b0;
    repeat (DB) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    no_key = 1'b1;
    repeat (DB + 4) @(posedge clk);
    check("t5_count_zero", 32'(digit_count), 32'd0);

    // Key held across enable rising, start ignored while disabled
    snap     = acc_seen;
    snap_err = err_seen;
    @(negedge clk);
    enable   = 1'b0;
    key_code = 4'd9;
    no_key   = 1'b0;
    repeat (DB + 4) @(posedge clk);
    do_start();
    @(negedge clk);
    enable = 1'b1;
    repeat (DB + 10) @(posedge clk);
    @(negedge clk);
    check("t6_held_no_accept", 32'(acc_seen - snap), 32'd0);
    check("t6_start_ignored",  32'(err_seen - snap_err), 32'd0);
    no_key = 1'b1;
    repeat (DB + 4) @(posedge clk);
    exp_acc(16'h0009, 3'd1, 1'b0);
    press(4'd9);

    // Reset in the middle of a press debounce
    snap = acc_seen;
    @(negedge clk);
    key_code = 4'd2;
    no_key   = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t7_rst_bcd",      32'(time_bcd),    32'h0);
    check("t7_rst_count",    32'(digit_count), 32'd0);
    check("t7_rst_valid",    32'(time_valid),  32'd0);
    check("t7_rst_time_out", 32'(time_out),    32'h0);
    check("t7_rst_accept",   32'(key_accept),  32'd0);
    repeat (DB + 4) @(posedge clk);
    @(negedge clk);
    no_key = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DB + 4) @(posedge clk);
    @(negedge clk);
    check("t7_no_pulse", 32'(acc_seen - snap), 32'd0);

    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Sequencing controller for the microwave keypad path. It consumes the priority encoder's digit code and no-key flag, then debounces each press and release. Accepted digits shift into a 4-digit BCD MM:SS entry register, and the validated time is handed to the cook timer on a start request. It sits between the keypad encoder and the countdown timer and owns all keypad entry state.

## Interface
- DEBOUNCE_CYCLES, 16, consecutive stable samples required to accept a press or a release (≥2)
- BEEP_CYCLES, 1000, beep pulse length in cycles (used only with KEYPAD_BEEP_EN)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  entry permitted (door closed, not cooking)
- key_code  in  4  encoder digit code, 0–9 valid
- no_key  in  1  encoder flag, 1 = no key pressed
- clear  in  1  clear-entry request, level-sampled
- start  in  1  start request, single-cycle pulse
- key_accept  out  1  one-cycle pulse per accepted press
- time_bcd  out  16  entry register {M1,M0,S1,S0}, one BCD digit per nibble
- digit_count  out  3  digits entered, 0–4
- overflow  out  1  sticky, a press arrived with 4 digits already held
- time_valid  out  1  digit_count≠0 and S1≤5
- load  out  1  one-cycle pulse, time_out valid
- time_out  out  16  time delivered to the timer, held until next load
- entry_err  out  1  one-cycle pulse, start rejected
- beep  out  1  key click

## Operation
- key_code and no_key are registered once before the FSM. All FSM decisions use the registered copies.
- FSM states are IDLE, PRESS_DB, HELD and RELEASE_DB.
- IDLE: when the sample shows a key with code ≤9, latch the code, set cnt=1 and go to PRESS_DB. Codes >9 are ignored.
- PRESS_DB, same code: cnt++. When cnt reaches DEBOUNCE_CYCLES, pulse key_accept and go to HELD.
- PRESS_DB, different code: relatch the code, set cnt=1 and stay.
- PRESS_DB, no_key: return to IDLE.
- HELD: on no_key, set cnt=1 and go to RELEASE_DB.
- RELEASE_DB, no_key: cnt++. When cnt reaches DEBOUNCE_CYCLES, go to IDLE.
- RELEASE_DB, any key: return to HELD with no new accept.
- On accept with digit_count<4: time_bcd ← {time_bcd[11:0], code} and digit_count++.
- On accept with digit_count=4: register unchanged and overflow set.
- clear: time_bcd, digit_count and overflow go to 0. The FSM is unaffected.
- start with time_valid=1: time_out ← time_bcd, pulse load, and clear the entry the same cycle.
- start with time_valid=0: pulse entry_err and leave the entry unchanged.
- enable=0: no accepts and start is ignored. The FSM is forced to IDLE if no_key, else HELD, so a key held across re-enable is never accepted.
- Priority within a cycle: clear > start > accept. A discarded accept still pulses key_accept, but the entry is not modified.
- Debounce counter width is $clog2(DEBOUNCE_CYCLES+1). It never wraps.

## Timing
- Reset values: every output is 0, the FSM is IDLE and all counters are 0.
- Reset mid-debounce or mid-beep aborts immediately, with no pulse emitted.
- Press latency: raw key stable from edge k gives key_accept high in the cycle after edge k+DEBOUNCE_CYCLES.
- time_bcd and digit_count update on the same edge that raises key_accept.
- load and entry_err are asserted the cycle after the start edge. time_out is stable from the load cycle onward.
- All outputs are registered. There are no combinational input→output paths.

## Configuration
- KEYPAD_BEEP_EN defined: beep goes high on the edge that raises key_accept and stays high for BEEP_CYCLES cycles.
- A new accept during a beep restarts the beep count.
- entry_err also triggers a beep.
- KEYPAD_BEEP_EN undefined: beep is tied to 0 and the beep counter is not synthesized.

## Structure
- Package keypad_pkg holds the FSM state enum (IDLE, PRESS_DB, HELD, RELEASE_DB), MAX_DIGITS=4 and MAX_SEC_TENS=4'd5.
- Sub-module key_debounce holds the input register, the FSM and the counter. It outputs accept_pulse and accept_code.
- The top level holds the entry register, start/clear handling and the beep.

## Test plan
- Press 7 for 16 cycles, then release for 16 cycles → one key_accept, time_bcd=16'h0007, digit_count=1.
- Key 3 bounces (3/none/3 alternating every 5 cycles), then holds 16 cycles → exactly one accept, after the stable window.
- Enter 1,2,3,0 then start → load pulse, time_out=16'h1230, time_bcd=0, digit_count=0.
- Enter 1,2,3,4,5 → time_bcd=16'h1234, overflow=1. Enter 1,7,5 then start → entry_err pulse, time_bcd=16'h0175 kept.
- clear and a key accept in the same cycle → key_accept pulses, entry stays 0.
- Hold 9 while enable rises → no accept until release and a fresh press. Assert rst_n=0 mid-PRESS_DB → all outputs 0, no pulse.
